// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand class encoding, skid FSM states
// and the helper that decides whether a class needs special-case handling.
package fp_pkg;

    localparam int CLS_W = 3;

    typedef enum logic [CLS_W-1:0] {
        CLS_ZERO = 3'd0,
        CLS_SUB  = 3'd1,
        CLS_NORM = 3'd2,
        CLS_INF  = 3'd3,
        CLS_NAN  = 3'd4
    } fp_class_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    function automatic logic is_special(input fp_class_e cls);
        return (cls == CLS_ZERO) || (cls == CLS_INF) || (cls == CLS_NAN);
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational classifier for one packed operand: returns its class, the
// effective exponent and the mantissa with the hidden bit made explicit.
module fp_classify
    import fp_pkg::*;
#(
    parameter int EXP_W     = 8,
    parameter int MAN_W     = 23,
    parameter int FLUSH_SUB = 0
) (
    input  logic [EXP_W-1:0] exp_f,
    input  logic [MAN_W-1:0] man_f,
    output fp_class_e        cls,
    output logic [EXP_W-1:0] e,
    output logic [MAN_W:0]   m
);

    logic exp_ones_s;
    logic exp_zero_s;
    logic man_zero_s;

    assign exp_ones_s = &exp_f;
    assign exp_zero_s = ~|exp_f;
    assign man_zero_s = ~|man_f;

    // Decode the exponent/mantissa fields into class, exponent and mantissa.
    always_comb begin
        cls = CLS_NORM;
        e   = exp_f;
        m   = {1'b1, man_f};
        if (exp_ones_s) begin
            cls = man_zero_s ? CLS_INF : CLS_NAN;
            m   = {1'b0, man_f};
        end else if (exp_zero_s) begin
            if (man_zero_s) begin
                cls = CLS_ZERO;
                m   = {1'b0, man_f};
            end else if (FLUSH_SUB != 0) begin
                cls = CLS_ZERO;
                e   = '0;
                m   = '0;
            end else begin
                // Subnormals share the minimum normal exponent, without hidden bit.
                cls = CLS_SUB;
                e   = {{(EXP_W-1){1'b0}}, 1'b1};
                m   = {1'b0, man_f};
            end
        end else begin
            cls = CLS_NORM;
            e   = exp_f;
            m   = {1'b1, man_f};
        end
    end

endmodule

// File: rtl/fp_operand_unpack.sv
// Unpacks an operand pair into sign/exponent/mantissa/class fields and hands
// them downstream through a two-entry skid buffer with a registered in_ready.
module fp_operand_unpack
    import fp_pkg::*;
#(
    parameter int  EXP_W     = 8,
    parameter int  MAN_W     = 23,
    parameter int  FLUSH_SUB = 0,
    localparam int W         = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             s_a,
    output logic             s_b,
    output logic             s_p,
    output logic [EXP_W-1:0] e_a,
    output logic [EXP_W-1:0] e_b,
    output logic [MAN_W:0]   m_a,
    output logic [MAN_W:0]   m_b,
    output logic [2:0]       cls_a,
    output logic [2:0]       cls_b,
    output logic             special
);

    localparam int PW = 3 + 2 * EXP_W + 2 * (MAN_W + 1) + 2 * CLS_W + 1;

    fp_class_e        cls_a_s;
    fp_class_e        cls_b_s;
    logic [EXP_W-1:0] e_a_s;
    logic [EXP_W-1:0] e_b_s;
    logic [MAN_W:0]   m_a_s;
    logic [MAN_W:0]   m_b_s;
    logic [PW-1:0]    pair_s;

    skid_state_e      state_r;
    skid_state_e      state_n_s;
    logic [PW-1:0]    main_r;
    logic [PW-1:0]    main_n_s;
    logic [PW-1:0]    skid_r;
    logic [PW-1:0]    skid_n_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             accept_s;
    logic             drain_s;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W), .FLUSH_SUB(FLUSH_SUB)) u_cls_a (
        .exp_f (a[W-2:MAN_W]),
        .man_f (a[MAN_W-1:0]),
        .cls   (cls_a_s),
        .e     (e_a_s),
        .m     (m_a_s)
    );

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W), .FLUSH_SUB(FLUSH_SUB)) u_cls_b (
        .exp_f (b[W-2:MAN_W]),
        .man_f (b[MAN_W-1:0]),
        .cls   (cls_b_s),
        .e     (e_b_s),
        .m     (m_b_s)
    );

    assign pair_s = {a[W-1], b[W-1], a[W-1] ^ b[W-1], e_a_s, e_b_s, m_a_s, m_b_s,
                     cls_a_s, cls_b_s, is_special(cls_a_s) || is_special(cls_b_s)};

    assign accept_s = in_valid && in_ready_r;
    assign drain_s  = out_valid_r && out_ready;

    // Skid FSM next state and main/skid entry updates.
    always_comb begin
        state_n_s = state_r;
        main_n_s  = main_r;
        skid_n_s  = skid_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_n_s = ST_ONE;
                    main_n_s  = pair_s;
                end else begin
                    state_n_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && drain_s) begin
                    main_n_s = pair_s;
                end else if (accept_s) begin
                    state_n_s = ST_TWO;
                    skid_n_s  = pair_s;
                end else if (drain_s) begin
                    state_n_s = ST_EMPTY;
                end else begin
                    state_n_s = ST_ONE;
                end
            end
            ST_TWO: begin
                if (drain_s) begin
                    state_n_s = ST_ONE;
                    main_n_s  = skid_r;
                end else begin
                    state_n_s = ST_TWO;
                end
            end
            default: begin
                state_n_s = ST_EMPTY;
            end
        endcase
    end

    // State, payload and handshake registers; in_ready looks ahead at the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            main_r      <= '0;
            skid_r      <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            main_r      <= main_n_s;
            skid_r      <= skid_n_s;
            in_ready_r  <= (state_n_s != ST_TWO);
            out_valid_r <= (state_n_s != ST_EMPTY);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign {s_a, s_b, s_p, e_a, e_b, m_a, m_b, cls_a, cls_b, special} = main_r;

endmodule

// File: tb/tb_fp_operand_unpack.sv
// Scoreboard bench: drivers push hand-computed expected pairs, per-DUT monitors
// pop and compare on every output transfer.
module tb_fp_operand_unpack;

    localparam int PW0 = 74;
    localparam int PWH = 42;
    localparam logic [2:0] C_ZERO = 3'd0;
    localparam logic [2:0] C_SUB  = 3'd1;
    localparam logic [2:0] C_NORM = 3'd2;
    localparam logic [2:0] C_INF  = 3'd3;
    localparam logic [2:0] C_NAN  = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // main DUT (default parameters)
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [31:0] a = 32'h0, b = 32'h0;
    logic s_a, s_b, s_p, special;
    logic [7:0] e_a, e_b;
    logic [23:0] m_a, m_b;
    logic [2:0] cls_a, cls_b;
    logic [PW0-1:0] obs_m;
    assign obs_m = {s_a, s_b, s_p, e_a, e_b, m_a, m_b, cls_a, cls_b, special};

    fp_operand_unpack dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .s_a(s_a), .s_b(s_b), .s_p(s_p),
        .e_a(e_a), .e_b(e_b), .m_a(m_a), .m_b(m_b), .cls_a(cls_a), .cls_b(cls_b),
        .special(special)
    );

    // flushing DUT
    logic f_in_valid = 1'b0, f_in_ready, f_out_valid, f_out_ready = 1'b1;
    logic [31:0] f_a = 32'h0, f_b = 32'h0;
    logic f_s_a, f_s_b, f_s_p, f_special;
    logic [7:0] f_e_a, f_e_b;
    logic [23:0] f_m_a, f_m_b;
    logic [2:0] f_cls_a, f_cls_b;
    logic [PW0-1:0] obs_f;
    assign obs_f = {f_s_a, f_s_b, f_s_p, f_e_a, f_e_b, f_m_a, f_m_b, f_cls_a, f_cls_b, f_special};

    fp_operand_unpack #(.FLUSH_SUB(1)) dut_f (
        .clk(clk), .rst(rst), .in_valid(f_in_valid), .in_ready(f_in_ready), .a(f_a), .b(f_b),
        .out_valid(f_out_valid), .out_ready(f_out_ready), .s_a(f_s_a), .s_b(f_s_b), .s_p(f_s_p),
        .e_a(f_e_a), .e_b(f_e_b), .m_a(f_m_a), .m_b(f_m_b), .cls_a(f_cls_a), .cls_b(f_cls_b),
        .special(f_special)
    );

    // half-precision DUT
    logic h_in_valid = 1'b0, h_in_ready, h_out_valid, h_out_ready = 1'b1;
    logic [15:0] h_a = 16'h0, h_b = 16'h0;
    logic h_s_a, h_s_b, h_s_p, h_special;
    logic [4:0] h_e_a, h_e_b;
    logic [10:0] h_m_a, h_m_b;
    logic [2:0] h_cls_a, h_cls_b;
    logic [PWH-1:0] obs_h;
    assign obs_h = {h_s_a, h_s_b, h_s_p, h_e_a, h_e_b, h_m_a, h_m_b, h_cls_a, h_cls_b, h_special};

    fp_operand_unpack #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .a(h_a), .b(h_b),
        .out_valid(h_out_valid), .out_ready(h_out_ready), .s_a(h_s_a), .s_b(h_s_b), .s_p(h_s_p),
        .e_a(h_e_a), .e_b(h_e_b), .m_a(h_m_a), .m_b(h_m_b), .cls_a(h_cls_a), .cls_b(h_cls_b),
        .special(h_special)
    );

    logic [PW0-1:0] q_m[$];
    logic [PW0-1:0] q_f[$];
    logic [PWH-1:0] q_h[$];

    function automatic logic [PW0-1:0] mk(input logic sa, sb, sp, input logic [7:0] ea, eb,
                                          input logic [23:0] ma, mb, input logic [2:0] ca, cb,
                                          input logic spc);
        return {sa, sb, sp, ea, eb, ma, mb, ca, cb, spc};
    endfunction

    function automatic logic [PWH-1:0] mk_h(input logic sa, sb, sp, input logic [4:0] ea, eb,
                                            input logic [10:0] ma, mb, input logic [2:0] ca, cb,
                                            input logic spc);
        return {sa, sb, sp, ea, eb, ma, mb, ca, cb, spc};
    endfunction

    task automatic check(input string name, input logic [PW0-1:0] got, input logic [PW0-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Drivers are entered and left at posedge+1.
    task automatic send_m(input logic [31:0] av, bv, input logic [PW0-1:0] ex, input bit push);
        bit g;
        int n = 0;
        if (push) q_m.push_back(ex);
        a = av; b = bv; in_valid = 1'b1;
        do begin
            g = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!g && n < 20);
        in_valid = 1'b0;
        if (!g) check("send_m_timeout", 1, 0);
    endtask

    task automatic send_f(input logic [31:0] av, bv, input logic [PW0-1:0] ex);
        bit g;
        int n = 0;
        q_f.push_back(ex);
        f_a = av; f_b = bv; f_in_valid = 1'b1;
        do begin
            g = f_in_ready;
            @(posedge clk); #1;
            n++;
        end while (!g && n < 20);
        f_in_valid = 1'b0;
        if (!g) check("send_f_timeout", 1, 0);
    endtask

    task automatic send_h(input logic [15:0] av, bv, input logic [PWH-1:0] ex);
        bit g;
        int n = 0;
        q_h.push_back(ex);
        h_a = av; h_b = bv; h_in_valid = 1'b1;
        do begin
            g = h_in_ready;
            @(posedge clk); #1;
            n++;
        end while (!g && n < 20);
        h_in_valid = 1'b0;
        if (!g) check("send_h_timeout", 1, 0);
    endtask

    task automatic drain_wait(input string name);
        int n = 0;
        while ((q_m.size() + q_f.size() + q_h.size()) != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, PW0'(q_m.size() + q_f.size() + q_h.size()), '0);
    endtask

    // Main DUT monitor and output-stability checker.
    initial begin
        logic [PW0-1:0] held;
        bit stall_prev;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) check("stall_stable", obs_m, held);
                if (out_valid && out_ready) begin
                    if (q_m.size() == 0) check("main_unexpected", obs_m, '0);
                    else check("main_pair", obs_m, q_m.pop_front());
                end
                stall_prev = out_valid && !out_ready;
                held = obs_m;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && f_out_valid && f_out_ready) begin
                if (q_f.size() == 0) check("flush_unexpected", obs_f, '0);
                else check("flush_pair", obs_f, q_f.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && h_out_valid && h_out_ready) begin
                n_cmp++;
                if (q_h.size() == 0) begin
                    n_bad++;
                    $display("FAIL half_unexpected got=%h", obs_h);
                end else begin
                    logic [PWH-1:0] ex;
                    ex = q_h.pop_front();
                    if (obs_h !== ex) begin
                        n_bad++;
                        $display("FAIL half_pair got=%h exp=%h", obs_h, ex);
                    end
                end
            end
        end
    end

    initial begin
        // reset state, with a pair held on the input throughout
        a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
        @(posedge clk); #1;
        check("reset_outputs", {in_ready, out_valid, obs_m}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", {in_ready, out_valid}, 2'b10);
        in_valid = 1'b0;

        // back-to-back directed vectors
        send_m(32'h3FC00000, 32'h40000000, mk(0,0,0, 8'h7F,8'h80, 24'hC00000,24'h800000, C_NORM,C_NORM, 0), 1);
        send_m(32'h00000001, 32'hBF800000, mk(0,1,1, 8'h01,8'h7F, 24'h000001,24'h800000, C_SUB,C_NORM, 0), 1);
        send_m(32'h7F800000, 32'h7FC00000, mk(0,0,0, 8'hFF,8'hFF, 24'h000000,24'h400000, C_INF,C_NAN, 1), 1);
        send_m(32'h00000000, 32'hC0400000, mk(0,1,1, 8'h00,8'h80, 24'h000000,24'hC00000, C_ZERO,C_NORM, 1), 1);
        send_m(32'h80000000, 32'hFF800000, mk(1,1,0, 8'h00,8'hFF, 24'h000000,24'h000000, C_ZERO,C_INF, 1), 1);
        send_m(32'h007FFFFF, 32'h00800000, mk(0,0,0, 8'h01,8'h01, 24'h7FFFFF,24'h800000, C_SUB,C_NORM, 0), 1);
        send_m(32'hFFC00001, 32'h3F800000, mk(1,0,1, 8'hFF,8'h7F, 24'h400001,24'h800000, C_NAN,C_NORM, 1), 1);
        drain_wait("drain_directed");

        // stream of 4 with downstream stalled for three cycles
        fork
            begin
                send_m(32'h3F800000, 32'h40400000, mk(0,0,0, 8'h7F,8'h80, 24'h800000,24'hC00000, C_NORM,C_NORM, 0), 1);
                send_m(32'h40800000, 32'h41000000, mk(0,0,0, 8'h81,8'h82, 24'h800000,24'h800000, C_NORM,C_NORM, 0), 1);
                send_m(32'hBF000000, 32'h3E800000, mk(1,0,1, 8'h7E,8'h7D, 24'h800000,24'h800000, C_NORM,C_NORM, 0), 1);
                send_m(32'h42C80000, 32'hC1200000, mk(0,1,1, 8'h85,8'h82, 24'hC80000,24'hA00000, C_NORM,C_NORM, 0), 1);
            end
            begin
                @(posedge clk); #1;
                out_ready = 1'b0;
                @(posedge clk); #1;
                check("stall_in_ready_low", {in_ready, out_valid}, 2'b01);
                @(posedge clk); #1;
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain_wait("drain_stream");

        // reset while two pairs are held
        out_ready = 1'b0;
        send_m(32'h40000000, 32'h40000000, '0, 0);
        send_m(32'h40400000, 32'h40400000, '0, 0);
        check("two_full_in_ready", {in_ready, out_valid}, 2'b01);
        #2 rst = 1'b1;
        #1 check("async_reset_clear", {in_ready, out_valid, obs_m}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("ready_after_midreset", {in_ready, out_valid}, 2'b10);
        repeat (4) @(posedge clk);
        #1 check("no_ghost_output", out_valid, 1'b0);

        // flushing and half-precision variants
        send_f(32'h00000001, 32'hBF800000, mk(0,1,1, 8'h00,8'h7F, 24'h000000,24'h800000, C_ZERO,C_NORM, 1));
        send_f(32'h807FFFFF, 32'h00000000, mk(1,0,1, 8'h00,8'h00, 24'h000000,24'h000000, C_ZERO,C_ZERO, 1));
        send_h(16'h3C00, 16'hC000, mk_h(0,1,1, 5'd15,5'd16, 11'h400,11'h400, C_NORM,C_NORM, 0));
        send_h(16'h0001, 16'h7C00, mk_h(0,0,0, 5'd1,5'd31, 11'h001,11'h000, C_SUB,C_INF, 1));
        drain_wait("drain_variants");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_operand_unpack.md
FP_OPERAND_UNPACK -- requirements
Module: fp_operand_unpack

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored-mantissa field width.
REQ-003 SHALL have parameter FLUSH_SUB, default 0; when 1, subnormal operands are treated as zero.
REQ-004 SHALL define W = 1+EXP_W+MAN_W; ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts the pair this cycle.
- a, b  in  W  packed operands {sign, exp, man}.
- out_valid  out  1  unpacked pair valid.
- out_ready  in  1  downstream accepts.
- s_a, s_b, s_p  out  1  operand signs; product sign s_a^s_b.
- e_a, e_b  out  EXP_W  effective exponents.
- m_a, m_b  out  MAN_W+1  mantissas with hidden bit.
- cls_a, cls_b  out  3  operand class (fp_pkg encoding).
- special  out  1  pair needs special-case handling.

Function
REQ-005 SHALL accept a pair on in_valid&&in_ready and present it on outputs exactly 1 cycle later; out_valid asserts in the following cycle.
REQ-006 SHALL transfer output on out_valid&&out_ready; all outputs SHALL stay stable while out_valid&&!out_ready.
REQ-007 SHALL implement a 2-entry skid: states EMPTY, ONE (main full), TWO (main+skid full).
REQ-008 Transitions: EMPTY-accept->ONE; ONE-accept&!drain->TWO; ONE-drain&!accept->EMPTY; ONE-accept&drain->ONE; TWO-drain->ONE (skid moves to main); all others hold.
REQ-009 in_ready SHALL be registered and equal state!=TWO, so it never depends combinationally on out_ready.
REQ-010 SHALL sustain one pair per cycle when out_ready stays high; no pair SHALL be lost or duplicated.
REQ-011 Class per operand: exp all-ones&man!=0 -> NAN; exp all-ones&man==0 -> INF; exp==0&man==0 -> ZERO; exp==0&man!=0 -> SUB, or ZERO when FLUSH_SUB=1; otherwise NORM.
REQ-012 NORM: e = exp, m = {1, man}. SUB (FLUSH_SUB=0): e = 1, m = {0, man}. ZERO/INF/NAN: e = exp, m = {0, man}; flushed SUB: e = 0, m = 0.
REQ-013 special SHALL be 1 when either class is ZERO, INF or NAN; 0 for NORM/SUB pairs.
REQ-014 s_p SHALL equal s_a^s_b for every class, NaN included.
REQ-015 Classification and unpacking SHALL be computed at acceptance and stored; no output SHALL be combinational from a or b.
REQ-016 Outputs SHALL retain the last transferred pair while out_valid=0.

Reset
REQ-017 On rst high: state=EMPTY, out_valid=0, in_ready=0, and all data/class outputs 0, asynchronously.
REQ-018 in_ready SHALL rise on the first clk edge after rst deasserts; a pair held during reset SHALL NOT be captured.
REQ-019 A pair in flight when rst asserts mid-operation SHALL be discarded; no partial output SHALL appear after reset.

Structure
REQ-020 fp_pkg SHALL hold the class encoding (ZERO=0, SUB=1, NORM=2, INF=3, NAN=4) and the class width constant.
REQ-021 Combinational sub-module fp_classify (parameters EXP_W, MAN_W, FLUSH_SUB) SHALL produce class, e and m for one operand and be instantiated twice.
REQ-022 The skid FSM and registers SHALL live in fp_operand_unpack; total RTL 120-400 lines.

Verification
REQ-023 Default params, a=0x3FC00000, b=0x40000000, out_ready=1 -> next cycle e_a=0x7F, m_a=0xC00000, e_b=0x80, m_b=0x800000, cls NORM/NORM, special=0, s_p=0.
REQ-024 a=0x00000001, b=0xBF800000: FLUSH_SUB=0 -> e_a=1, m_a=0x000001, cls_a=SUB, special=0, s_p=1; FLUSH_SUB=1 -> cls_a=ZERO, m_a=0, special=1.
REQ-025 a=0x7F800000, b=0x7FC00000 -> cls_a=INF, cls_b=NAN, special=1.
REQ-026 Stream 4 pairs, out_ready low cycles 2-4 -> in_ready low after 2 accepts, outputs stable, all 4 delivered in order without loss or duplication.
REQ-027 Assert rst in state TWO -> out_valid=0 and outputs 0 immediately; in_ready=1 one edge after release; the held pairs never appear.
REQ-028 EXP_W=5, MAN_W=10, a=0x3C00 -> e_a=15, m_a=0x400, cls_a=NORM.
